seq_pattern_gen: RTL and testbench

//  Serial stimulus source for the sequence-detector family: loads a parallel bit

---
 rtl/seq_pattern_gen.sv | 183 ++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern source: latches a parallel pattern and shifts it out MSB-first
// (bit len-1 first), optionally repeating it with idle gaps between passes.
module seq_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   rep,
  input  logic [GAP_W-1:0]   gap,
  output logic               x_out,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] pat_reg, pat_next;
  logic [IDX_W-1:0]   last_idx_reg, last_idx_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [REP_W-1:0]   rep_reg, rep_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               x_out_reg, x_out_next;
  logic               x_valid_reg, x_valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic               len_legal;
  logic [IDX_W-1:0]   start_idx;

  // Bit select written as a compare loop so the index width never has to match
  // the pattern width exactly.
  function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [IDX_W-1:0] i);
    logic b;
    b = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (i == IDX_W'(k)) b = p[k];
    end
    return b;
  endfunction

  assign len_legal = (len != '0) && (len <= MAX_LEN_L);
  assign start_idx = IDX_W'(len - LEN_W'(1));

  always_comb begin
    state_next    = state_reg;
    pat_next      = pat_reg;
    last_idx_next = last_idx_reg;
    idx_next      = idx_reg;
    rep_next      = rep_reg;
    gap_next      = gap_reg;
    gap_cnt_next  = gap_cnt_reg;
    x_out_next    = 1'b0;
    x_valid_next  = 1'b0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_legal) begin
            state_next    = SHIFT;
            pat_next      = pattern;
            last_idx_next = start_idx;
            rep_next      = rep;
            gap_next      = gap;
            idx_next      = start_idx;
            x_out_next    = pick(pattern, start_idx);
            x_valid_next  = 1'b1;
            busy_next     = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (idx_reg != '0) begin
          idx_next     = idx_reg - IDX_W'(1);
          x_out_next   = pick(pat_reg, idx_reg - IDX_W'(1));
          x_valid_next = 1'b1;
          busy_next    = 1'b1;
        end else if (rep_reg != '0) begin
          rep_next  = rep_reg - REP_W'(1);
          busy_next = 1'b1;
          if (gap_reg != '0) begin
            state_next   = GAP;
            gap_cnt_next = gap_reg;
          end else begin
            // Back-to-back passes: next pass's first bit follows with no bubble.
            idx_next     = last_idx_reg;
            x_out_next   = pick(pat_reg, last_idx_reg);
            x_valid_next = 1'b1;
          end
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      GAP: begin
        busy_next = 1'b1;
        if (gap_cnt_reg == GAP_W'(1)) begin
          state_next   = SHIFT;
          gap_cnt_next = '0;
          idx_next     = last_idx_reg;
          x_out_next   = pick(pat_reg, last_idx_reg);
          x_valid_next = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides every transition above, including a pending done.
    if (abort && (state_reg != IDLE)) begin
      state_next   = IDLE;
      gap_cnt_next = '0;
      idx_next     = '0;
      x_out_next   = 1'b0;
      x_valid_next = 1'b0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      err_next     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pat_reg      <= '0;
      last_idx_reg <= '0;
      idx_reg      <= '0;
      rep_reg      <= '0;
      gap_reg      <= '0;
      gap_cnt_reg  <= '0;
      x_out_reg    <= 1'b0;
      x_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pat_reg      <= pat_next;
      last_idx_reg <= last_idx_next;
      idx_reg      <= idx_next;
      rep_reg      <= rep_next;
      gap_reg      <= gap_next;
      gap_cnt_reg  <= gap_cnt_next;
      x_out_reg    <= x_out_next;
      x_valid_reg  <= x_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign x_out   = x_out_reg;
  assign x_valid = x_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus pushes the expected per-cycle
// event stream (bit / gap / done / err); a negedge monitor pops and compares.
module tb_seq_pattern_gen;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int REP_W   = 8;
  localparam int GAP_W   = 4;

  localparam logic [1:0] K_BIT  = 2'd0;
  localparam logic [1:0] K_GAP  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic       bit_val;
    int         busy_len;
  } ev_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [REP_W-1:0]   rep;
  logic [GAP_W-1:0]   gap;
  logic               x_out;
  logic               x_valid;
  logic               busy;
  logic               done;
  logic               err;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  busy_cnt = 0;

  seq_pattern_gen #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .rep(rep), .gap(gap),
    .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: classify each cycle's output and check it against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      logic       have_ev;
      logic [1:0] kind;
      ev_t        e;
      have_ev = 1'b1;
      kind    = K_BIT;
      if (x_valid)     kind = K_BIT;
      else if (done)   kind = K_DONE;
      else if (err)    kind = K_ERR;
      else if (busy)   kind = K_GAP;
      else             have_ev = 1'b0;

      if (!x_valid && (busy || done)) begin
        total++;
        if (x_out !== 1'b0) begin
          bad++;
          $display("FAIL x_out_idle: got %b want 0 at %0t", x_out, $time);
        end
      end

      if (have_ev) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got kind %0d (x_out=%b) with empty queue at %0t",
                   kind, x_out, $time);
        end else begin
          e = sb.pop_front();
          if (e.kind != kind) begin
            bad++;
            $display("FAIL event_kind: got %0d want %0d at %0t", kind, e.kind, $time);
          end else if (kind == K_BIT && x_out !== e.bit_val) begin
            bad++;
            $display("FAIL serial_bit: got %b want %b at %0t", x_out, e.bit_val, $time);
          end else if (kind == K_DONE) begin
            total++;
            if (busy_cnt != e.busy_len) begin
              bad++;
              $display("FAIL busy_len: got %0d want %0d at %0t", busy_cnt, e.busy_len, $time);
            end
          end
        end
      end

      if (done)      busy_cnt = 0;
      else if (busy) busy_cnt++;
      else           busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_bits(input string bits);
    ev_t e;
    for (int i = 0; i < bits.len(); i++) begin
      e.kind = K_BIT;
      e.bit_val = (bits[i] == "1");
      e.busy_len = 0;
      sb.push_back(e);
    end
  endtask

  // Push the expected stream for one accepted transfer, then pulse start.
  task automatic start_xfer(input logic [MAX_LEN-1:0] p, input int l, input int r,
                            input int g, input string pass_bits, input int busy_exp);
    ev_t e;
    for (int pass = 0; pass <= r; pass++) begin
      push_bits(pass_bits);
      if (pass < r) begin
        for (int k = 0; k < g; k++) begin
          e.kind = K_GAP; e.bit_val = 1'b0; e.busy_len = 0;
          sb.push_back(e);
        end
      end
    end
    e.kind = K_DONE; e.bit_val = 1'b0; e.busy_len = busy_exp;
    sb.push_back(e);
    @(posedge clk); #1;
    pattern = p; len = LEN_W'(l); rep = REP_W'(r); gap = GAP_W'(g); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    $display("xfer pattern=%b len=%0d rep=%0d gap=%0d bits=%s busy=%0d",
             p, l, r, g, pass_bits, busy_exp);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (sb.size() > 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d events still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reject(input int l);
    ev_t e;
    e.kind = K_ERR; e.bit_val = 1'b0; e.busy_len = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    pattern = 8'hFF; len = LEN_W'(l); rep = '0; gap = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("reject_busy", busy, 1'b0);
    check("reject_valid", x_valid, 1'b0);
    $display("reject len=%0d", l);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; rep = '0; gap = '0;
    #1;
    check("reset_x_out", x_out, 1'b0);
    check("reset_x_valid", x_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single pass, with first-bit latency check.
    start_xfer(8'b0000_1011, 4, 0, 0, "1011", 4);
    check("latency_valid", x_valid, 1'b1);
    check("latency_first_bit", x_out, 1'b1);
    check("latency_busy", busy, 1'b1);
    wait_drain(50);

    start_xfer(8'b0000_1011, 4, 1, 2, "1011", 10);
    wait_drain(50);
    start_xfer(8'b0000_0101, 3, 2, 0, "101", 9);
    wait_drain(50);
    start_xfer(8'b0000_0001, 1, 2, 1, "1", 5);
    wait_drain(50);
    start_xfer(8'b1010_0101, 8, 0, 0, "10100101", 8);
    wait_drain(50);
    start_xfer(8'b0000_1010, 4, 0, 0, "1010", 4);
    wait_drain(50);
    start_xfer(8'b0000_1101, 4, 1, 0, "1101", 8);
    wait_drain(50);

    reject(0);
    reject(9);
    wait_drain(10);

    // Re-asserted start with new inputs mid-transfer must be ignored.
    start_xfer(8'b0000_1011, 4, 0, 0, "1011", 4);
    pattern = 8'hFF; len = 4'd8; rep = 8'd3; gap = 4'd1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_drain(50);

    // Abort while the 2nd bit is on the line: no further bits, no done.
    begin
      ev_t e;
      push_bits("10");
      @(posedge clk); #1;
      pattern = 8'b0000_1011; len = 4'd4; rep = 8'd0; gap = 4'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_valid", x_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_x_out", x_out, 1'b0);
      e.kind = K_BIT;
      $display("abort after 2 bits");
      wait_drain(10);
    end

    // Asynchronous reset between edges during a long transfer.
    start_xfer(8'b1100_1010, 8, 3, 2, "11001010", 38);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x_out", x_out, 1'b0);
    check("async_rst_valid", x_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    sb.delete();
    $display("async reset mid-shift");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    start_xfer(8'b0000_1011, 4, 1, 1, "1011", 9);
    wait_drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
